// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and access-size helper shared by the LSU byte initiator
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DRAIN, S_RESP} state_t;
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    return f3[1] ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/lsu_byte_initiator_if.sv
// lsu_byte_initiator_if: request/response handshake and byte-wide memory bus of the LSU byte initiator
// master: the initiator (takes requests, drives responses and memory transactions)
// slave:  the environment (core plus memory)
interface lsu_byte_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of the assembled load word selected by funct3
// asm_data in 32 assembled bytes, funct3 in 3 size/extension, result out 32 extended data
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] asm_data,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  always_comb
    result = funct3 == F3_B  ? {{24{asm_data[7]}}, asm_data[7:0]} :
             funct3 == F3_H  ? {{16{asm_data[15]}}, asm_data[15:0]} :
             funct3 == F3_BU ? {24'd0, asm_data[7:0]} :
             funct3 == F3_HU ? {16'd0, asm_data[15:0]} : asm_data;
endmodule

// File: rtl/lsu_byte_initiator.sv
// lsu_byte_initiator: serialises one load/store into 1/2/4 byte-wide memory transactions and returns extended load data
// clk, rst_n (async active-low); bus: lsu_byte_initiator_if.master carrying req_*, resp_* and mem_* signals
// DATA_BASE: byte offset added to every request address
// LSU_MISALIGN_TRAP_EN (define): reject misaligned halfword/word requests instead of servicing them bytewise
module lsu_byte_initiator
  import lsu_pkg::*;
#(
  parameter int DATA_BASE = 127
) (
  input logic                  clk,
  input logic                  rst_n,
  lsu_byte_initiator_if.master bus
);
  state_t      state;
  logic        wr;
  logic [2:0]  f3;
  logic [7:0]  base;
  logic [31:0] wdata;
  logic [1:0]  last;
  logic [1:0]  idx;
  logic [1:0]  nxt;
  logic [1:0]  cap_idx;
  logic [31:0] asm_q;
  logic [31:0] asm_next;
  logic [31:0] ext_res;
  logic        illegal;
  always_comb begin
    illegal = bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11 || (bus.req_write && bus.req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    illegal = illegal || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
              (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00);
`endif
  end
  // Read data lags its issuing cycle by one: in ACCESS the bus carries byte idx-1, in DRAIN the last byte.
  always_comb begin
    nxt = idx + 2'd1;
    cap_idx = state == S_DRAIN ? idx : idx - 2'd1;
    asm_next = asm_q;
    if (!wr && (state == S_DRAIN || (state == S_ACCESS && idx != 2'd0)))
      asm_next[{cap_idx, 3'b000} +: 8] = bus.mem_rdata;
  end
  lsu_extend u_ext (
    .asm_data(asm_next),
    .funct3  (f3),
    .result  (ext_res)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wr             <= 1'b0;
      f3             <= '0;
      base           <= '0;
      wdata          <= '0;
      last           <= '0;
      idx            <= '0;
      asm_q          <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.req_valid) begin
          wr            <= bus.req_write;
          f3            <= bus.req_funct3;
          base          <= 8'(bus.req_addr + DATA_BASE);
          wdata         <= bus.req_wdata;
          last          <= 2'(size_of(bus.req_funct3) - 3'd1);
          idx           <= '0;
          asm_q         <= '0;
          bus.req_ready <= 1'b0;
          if (illegal) begin
            state          <= S_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
          end else begin
            state         <= S_ACCESS;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.req_write;
            bus.mem_addr  <= 8'(bus.req_addr + DATA_BASE);
            bus.mem_wdata <= bus.req_wdata[7:0];
          end
        end
        S_ACCESS: begin
          asm_q <= asm_next;
          if (idx == last) begin
            state          <= wr ? S_RESP : S_DRAIN;
            bus.resp_valid <= wr;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
          end else begin
            idx           <= nxt;
            bus.mem_addr  <= base + {6'd0, nxt};
            bus.mem_wdata <= wdata[{nxt, 3'b000} +: 8];
          end
        end
        S_DRAIN: begin
          state          <= S_RESP;
          asm_q          <= asm_next;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= ext_res;
        end
        default: begin
          state          <= S_IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_byte_initiator.sv
// tb_lsu_byte_initiator: directed scoreboard bench for lsu_byte_initiator with a byte memory model
module tb_lsu_byte_initiator;
  import lsu_pkg::*;
  typedef struct {int cyc; logic [31:0] d; logic e;} rsp_t;
  typedef struct {int cyc; logic we; logic [7:0] a; logic [7:0] d;} mtx_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic [7:0] mem [256];
  rsp_t rq[$];
  mtx_t mq[$];
  lsu_byte_initiator_if bus ();
  lsu_byte_initiator #(.DATA_BASE(127)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  initial begin
    rsp_t r;
    mtx_t m;
    forever begin
      @(negedge clk);
      if (rst_n && bus.resp_valid) begin
        tests++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL resp_unexpected cyc=%0d rdata=%h err=%b", cyc, bus.resp_rdata, bus.resp_err);
        end else begin
          r = rq.pop_front();
          if (cyc != r.cyc || bus.resp_rdata !== r.d || bus.resp_err !== r.e) begin
            fails++;
            $display("FAIL resp got cyc=%0d rdata=%h err=%b want cyc=%0d rdata=%h err=%b",
                     cyc, bus.resp_rdata, bus.resp_err, r.cyc, r.d, r.e);
          end
        end
      end
      if (rst_n && bus.mem_en) begin
        tests++;
        if (mq.size() == 0) begin
          fails++;
          $display("FAIL mem_unexpected cyc=%0d we=%b addr=%0d wdata=%h", cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end else begin
          m = mq.pop_front();
          if (cyc != m.cyc || bus.mem_we !== m.we || bus.mem_addr !== m.a || bus.mem_wdata !== m.d) begin
            fails++;
            $display("FAIL mem got cyc=%0d we=%b addr=%0d wdata=%h want cyc=%0d we=%b addr=%0d wdata=%h",
                     cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata, m.cyc, m.we, m.a, m.d);
          end
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
  endtask
  task automatic issue(input logic w, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 8'hEE;
    bus.req_wdata  = 32'hDEADBEEF;
  endtask
  // n = bytes expected on the bus (0 for rejected requests)
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd,
                        input int n, input logic [31:0] exp_d, input logic exp_e);
    int c;
    wait_ready();
    c = cyc;
    for (int k = 0; k < n; k++) mq.push_back('{c + 1 + k, w, 8'(a + 8'd127 + 8'(k)), wd[8*k +: 8]});
    rq.push_back('{c + (exp_e ? 1 : w ? n + 1 : n + 2), exp_d, exp_e});
    issue(w, f3, a, wd);
  endtask
  initial begin
    int c;
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int c;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[131] = 8'h09;
    mem[140] = 8'h80;
    mem[141] = 8'hFF;
    mem[255] = 8'h34;
    mem[0]   = 8'h92;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 8'h00;
    bus.req_wdata  = 32'h0;
    bus.mem_rdata  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset_outs", {bus.mem_en, bus.mem_we, bus.resp_valid, bus.resp_err, bus.mem_addr, bus.mem_wdata},
        32'd0);
    chk("reset_rdata", bus.resp_rdata, 32'd0);
    do_req(1'b0, F3_W,  8'd4,   32'h0, 4, 32'h00000009, 1'b0);
    do_req(1'b0, F3_B,  8'd13,  32'h0, 1, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, F3_BU, 8'd13,  32'h0, 1, 32'h00000080, 1'b0);
    do_req(1'b0, F3_H,  8'd13,  32'h0, 2, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, F3_HU, 8'd12,  32'h0, 2, 32'h00008000, 1'b0);
    do_req(1'b0, F3_H,  8'd128, 32'h0, 2, 32'hFFFF9234, 1'b0);
    do_req(1'b1, F3_H,  8'd8,   32'h1234ABCD, 2, 32'h0, 1'b0);
    do_req(1'b1, F3_W,  8'd130, 32'hA1B2C3D4, 4, 32'h0, 1'b0);
    do_req(1'b0, 3'b011, 8'd4,  32'h0, 0, 32'h0, 1'b1);
    do_req(1'b0, 3'b111, 8'd4,  32'h0, 0, 32'h0, 1'b1);
    do_req(1'b1, F3_BU, 8'd4,   32'h55, 0, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, F3_W,  8'd2,   32'h0, 0, 32'h0, 1'b1);
`else
    do_req(1'b0, F3_W,  8'd2,   32'h0, 4, 32'h00090000, 1'b0);
`endif
    wait_ready();
    chk("mem135", {24'd0, mem[135]}, 32'hCD);
    chk("mem136", {24'd0, mem[136]}, 32'hAB);
    chk("mem1_4", {mem[4], mem[3], mem[2], mem[1]}, 32'hA1B2C3D4);
    c = cyc;
    mq.push_back('{c + 1, 1'b1, 8'd127, 8'h44});
    mq.push_back('{c + 2, 1'b1, 8'd128, 8'h33});
    issue(1'b1, F3_W, 8'd0, 32'h11223344);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {bus.mem_en, bus.mem_we, bus.resp_valid, bus.resp_err, bus.mem_addr, bus.mem_wdata},
        32'd0);
    chk("rst_mid_rdata", bus.resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_mem", {mem[130], mem[129], mem[128], mem[127]}, 32'h00003344);
    chk("rsp_queue_empty", rq.size(), 32'd0);
    chk("mem_queue_empty", mq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
